// File: rtl/dac_wave_ctrl.sv
// Square-wave DAC sequencer: HIGH/LOW half-periods with finite or continuous bursts
// and a one-entry command shadow. Optional abort input under DAC_WAVE_CTRL_ABORT_EN.
module dac_wave_ctrl #(
    parameter logic [15:0] DEF_HALF = 16'd300
) (
    input  logic        clk,
    input  logic        rst,
`ifdef DAC_WAVE_CTRL_ABORT_EN
    input  logic        abort,
`endif
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_half,
    input  logic [7:0]  cmd_amp,
    input  logic [7:0]  cmd_burst,
    output logic [7:0]  dac_out,
    output logic        busy,
    output logic        period_done,
    output logic        burst_done
);

    // state | meaning
    // IDLE  | no active waveform, dac_out = 0
    // HIGH  | first half of the period, dac_out = active amp
    // LOW   | second half of the period, dac_out = 0
    typedef enum logic [1:0] {IDLE = 2'd0, HIGH = 2'd1, LOW = 2'd2} state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] half_q, half_d;
    logic [7:0]  amp_q, amp_d;
    logic [7:0]  burst_q, burst_d;
    logic        sh_full_q, sh_full_d;
    logic [15:0] sh_half_q, sh_half_d;
    logic [7:0]  sh_amp_q, sh_amp_d;
    logic [7:0]  sh_burst_q, sh_burst_d;
    logic [7:0]  dac_q, dac_d;
    logic        pd_q, pd_d;
    logic        bd_q, bd_d;

    logic        accept;
    logic        half_last;
    logic        abort_act;
    logic [15:0] cmd_half_eff;

`ifdef DAC_WAVE_CTRL_ABORT_EN
    assign abort_act = abort;
`else
    assign abort_act = 1'b0;
`endif

    assign cmd_ready    = !sh_full_q;
    assign accept       = cmd_valid && cmd_ready;
    assign cmd_half_eff = (cmd_half == 16'd0) ? DEF_HALF : cmd_half;
    // half_q is never zero, so the subtraction cannot wrap
    assign half_last    = (cnt_q == half_q - 16'd1);

    assign dac_out     = dac_q;
    assign busy        = (state_q != IDLE);
    assign period_done = pd_q;
    assign burst_done  = bd_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        half_d     = half_q;
        amp_d      = amp_q;
        burst_d    = burst_q;
        sh_full_d  = sh_full_q;
        sh_half_d  = sh_half_q;
        sh_amp_d   = sh_amp_q;
        sh_burst_d = sh_burst_q;
        dac_d      = dac_q;
        pd_d       = 1'b0;
        bd_d       = 1'b0;

        if (abort_act) begin
            state_d   = IDLE;
            cnt_d     = 16'd0;
            sh_full_d = 1'b0;
            dac_d     = 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        half_d  = cmd_half_eff;
                        amp_d   = cmd_amp;
                        burst_d = cmd_burst;
                        state_d = HIGH;
                        cnt_d   = 16'd0;
                        dac_d   = cmd_amp;
                    end
                end
                HIGH: begin
                    if (accept) begin
                        sh_full_d  = 1'b1;
                        sh_half_d  = cmd_half_eff;
                        sh_amp_d   = cmd_amp;
                        sh_burst_d = cmd_burst;
                    end
                    if (half_last) begin
                        state_d = LOW;
                        cnt_d   = 16'd0;
                        dac_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                LOW: begin
                    if (!half_last) begin
                        cnt_d = cnt_q + 16'd1;
                        if (accept) begin
                            sh_full_d  = 1'b1;
                            sh_half_d  = cmd_half_eff;
                            sh_amp_d   = cmd_amp;
                            sh_burst_d = cmd_burst;
                        end
                    end else begin
                        // period end: a pending command always wins over the remaining burst
                        pd_d  = 1'b1;
                        cnt_d = 16'd0;
                        if (sh_full_q) begin
                            half_d    = sh_half_q;
                            amp_d     = sh_amp_q;
                            burst_d   = sh_burst_q;
                            sh_full_d = 1'b0;
                            state_d   = HIGH;
                            dac_d     = sh_amp_q;
                        end else if (accept) begin
                            half_d  = cmd_half_eff;
                            amp_d   = cmd_amp;
                            burst_d = cmd_burst;
                            state_d = HIGH;
                            dac_d   = cmd_amp;
                        end else if (burst_q == 8'd0) begin
                            state_d = HIGH;
                            dac_d   = amp_q;
                        end else if (burst_q == 8'd1) begin
                            burst_d = 8'd0;
                            state_d = IDLE;
                            dac_d   = 8'd0;
                            bd_d    = 1'b1;
                        end else begin
                            burst_d = burst_q - 8'd1;
                            state_d = HIGH;
                            dac_d   = amp_q;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 16'd0;
                    dac_d   = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 16'd0;
            half_q     <= DEF_HALF;
            amp_q      <= 8'd0;
            burst_q    <= 8'd0;
            sh_full_q  <= 1'b0;
            sh_half_q  <= DEF_HALF;
            sh_amp_q   <= 8'd0;
            sh_burst_q <= 8'd0;
            dac_q      <= 8'd0;
            pd_q       <= 1'b0;
            bd_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            half_q     <= half_d;
            amp_q      <= amp_d;
            burst_q    <= burst_d;
            sh_full_q  <= sh_full_d;
            sh_half_q  <= sh_half_d;
            sh_amp_q   <= sh_amp_d;
            sh_burst_q <= sh_burst_d;
            dac_q      <= dac_d;
            pd_q       <= pd_d;
            bd_q       <= bd_d;
        end
    end

endmodule

// File: tb/tb_dac_wave_ctrl.sv
// Bench for dac_wave_ctrl: table of whole-burst vectors, hand sequences for the
// shadow/boundary cases, and random traffic against a period-position reference model.
module tb_dac_wave_ctrl;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_half;
    logic [7:0]  cmd_amp;
    logic [7:0]  cmd_burst;
    logic [7:0]  dac_out;
    logic        busy;
    logic        period_done;
    logic        burst_done;
`ifdef DAC_WAVE_CTRL_ABORT_EN
    logic        abort;
`endif

    int checks = 0;
    int errors = 0;

    dac_wave_ctrl #(.DEF_HALF(16'd300)) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef DAC_WAVE_CTRL_ABORT_EN
        .abort       (abort),
`endif
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_half    (cmd_half),
        .cmd_amp     (cmd_amp),
        .cmd_burst   (cmd_burst),
        .dac_out     (dac_out),
        .busy        (busy),
        .period_done (period_done),
        .burst_done  (burst_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model: position within the full period ----------------
    typedef struct {
        int half;
        int amp;
        int burst;
    } cmd_t;

    cmd_t pend[$];
    bit   m_active = 0;
    int   m_pos = 0;
    int   m_half = 300;
    int   m_amp = 0;
    int   m_rem = 0;
    bit   m_cont = 0;
    bit   m_pd = 0;
    bit   m_bd = 0;

    task automatic m_load(input cmd_t c);
        m_half = (c.half == 0) ? 300 : c.half;
        m_amp  = c.amp;
        m_rem  = c.burst;
        m_cont = (c.burst == 0);
        m_pos  = 0;
    endtask

    task automatic model_step();
        bit   acc;
        bit   ab;
        cmd_t c;
        c.half  = int'(cmd_half);
        c.amp   = int'(cmd_amp);
        c.burst = int'(cmd_burst);
        acc  = cmd_valid && (pend.size() == 0);
        ab   = 1'b0;
`ifdef DAC_WAVE_CTRL_ABORT_EN
        ab   = abort;
`endif
        m_pd = 0;
        m_bd = 0;
        if (rst || ab) begin
            m_active = 0;
            m_pos    = 0;
            pend.delete();
        end else if (!m_active) begin
            if (acc) begin
                m_load(c);
                m_active = 1;
            end
        end else if (m_pos == 2 * m_half - 1) begin
            m_pd = 1;
            if (pend.size() != 0) begin
                m_load(pend.pop_front());
            end else if (acc) begin
                m_load(c);
            end else if (m_cont) begin
                m_pos = 0;
            end else begin
                m_rem--;
                if (m_rem == 0) begin
                    m_active = 0;
                    m_bd     = 1;
                end else begin
                    m_pos = 0;
                end
            end
        end else begin
            m_pos++;
            if (acc) pend.push_back(c);
        end
    endtask

    always @(posedge clk) begin
        model_step();
        #2;
        check("mon_dac", 16'(dac_out), (m_active && m_pos < m_half) ? 16'(m_amp) : 16'd0);
        check("mon_busy", 16'(busy), 16'(m_active));
        check("mon_ready", 16'(cmd_ready), 16'(pend.size() == 0));
        check("mon_period_done", 16'(period_done), 16'(m_pd));
        check("mon_burst_done", 16'(burst_done), 16'(m_bd));
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input int h, input int a, input int b);
        cmd_half  = 16'(h);
        cmd_amp   = 8'(a);
        cmd_burst = 8'(b);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 3000) begin
            tick();
            n++;
        end
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s: timeout, busy=%0b expected 0", name, busy);
        end
    endtask

    typedef struct {
        int half;
        int amp;
        int burst;
        int exp_busy;
        int exp_nz;
        int exp_pd;
        int exp_bd;
    } vec_t;

    vec_t tbl[5];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{4,   200, 2, 16,  8,   2, 1};
        tbl[1] = '{0,   255, 1, 600, 300, 1, 1};
        tbl[2] = '{1,   7,   3, 6,   3,   3, 1};
        tbl[3] = '{2,   0,   2, 8,   0,   2, 1};
        tbl[4] = '{5,   1,   1, 10,  5,   1, 1};

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_half  = 16'd0;
        cmd_amp   = 8'd0;
        cmd_burst = 8'd0;
`ifdef DAC_WAVE_CTRL_ABORT_EN
        abort     = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;
        check("reset_dac", 16'(dac_out), 16'd0);
        check("reset_busy", 16'(busy), 16'd0);
        check("reset_ready", 16'(cmd_ready), 16'd1);
        check("reset_pd", 16'(period_done), 16'd0);
        check("reset_bd", 16'(burst_done), 16'd0);
        tick();

        // whole-burst vectors
        for (int i = 0; i < 5; i++) begin
            int nb, nz, np, nd, n;
            nb = 0; nz = 0; np = 0; nd = 0; n = 0;
            send(tbl[i].half, tbl[i].amp, tbl[i].burst);
            check("vec_first_dac", 16'(dac_out), 16'(tbl[i].amp));
            while (n < 3000) begin
                if (busy === 1'b1) nb++;
                if (dac_out !== 8'd0) nz++;
                if (period_done === 1'b1) np++;
                if (burst_done === 1'b1) nd++;
                if (busy !== 1'b1) break;
                tick();
                n++;
            end
            check("vec_busy_cycles", 16'(nb), 16'(tbl[i].exp_busy));
            check("vec_high_cycles", 16'(nz), 16'(tbl[i].exp_nz));
            check("vec_period_pulses", 16'(np), 16'(tbl[i].exp_pd));
            check("vec_burst_pulses", 16'(nd), 16'(tbl[i].exp_bd));
            tick();
        end

        // continuous run replaced mid-period by a shadowed command
        send(3, 100, 0);
        tick();
        send(5, 50, 2);
        check("shadow_ready_low", 16'(cmd_ready), 16'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("shadow_ready_hold", 16'(cmd_ready), 16'd0);
        end
        tick();
        check("shadow_ready_back", 16'(cmd_ready), 16'd1);
        check("shadow_period_pulse", 16'(period_done), 16'd1);
        for (int i = 0; i < 10; i++) begin
            check("shadow_next_period", 16'(dac_out), (i < 5) ? 16'd50 : 16'd0);
            tick();
        end
        wait_idle("shadow_burst_end");
        tick();

        // last period of a burst meets a same-edge accept
        send(3, 30, 1);
        for (int i = 0; i < 5; i++) tick();
        send(2, 10, 1);
        check("edge_accept_dac", 16'(dac_out), 16'd10);
        check("edge_accept_busy", 16'(busy), 16'd1);
        check("edge_accept_no_bd", 16'(burst_done), 16'd0);
        check("edge_accept_pd", 16'(period_done), 16'd1);
        wait_idle("edge_accept_end");
        tick();

`ifdef DAC_WAVE_CTRL_ABORT_EN
        send(4, 20, 0);
        send(6, 60, 1);
        check("abort_shadow_full", 16'(cmd_ready), 16'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_dac", 16'(dac_out), 16'd0);
        check("abort_busy", 16'(busy), 16'd0);
        check("abort_ready", 16'(cmd_ready), 16'd1);
        check("abort_no_bd", 16'(burst_done), 16'd0);
        tick();
`endif

        // random traffic, checked by the model on every cycle
        for (int i = 0; i < 1500; i++) begin
            rst       = ($urandom_range(0, 199) == 0);
            cmd_valid = ($urandom_range(0, 7) == 0);
            cmd_half  = ($urandom_range(0, 39) == 0) ? 16'd0 : 16'($urandom_range(1, 6));
            cmd_amp   = 8'($urandom_range(0, 255));
            cmd_burst = 8'($urandom_range(0, 3));
`ifdef DAC_WAVE_CTRL_ABORT_EN
            abort     = ($urandom_range(0, 99) == 0);
`endif
            tick();
        end
        cmd_valid = 1'b0;
`ifdef DAC_WAVE_CTRL_ABORT_EN
        abort     = 1'b0;
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dac_wave_ctrl.md
DAC_WAVE_CTRL -- requirements
Module: dac_wave_ctrl

Interface
REQ-001 SHALL have parameter DEF_HALF: default 16'd300; half-period applied when a command carries 0.
REQ-002 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port cmd_valid, input, 1; command offered.
REQ-005 SHALL have port cmd_ready, output, 1; command can be accepted. Accept = cmd_valid && cmd_ready on a clock edge.
REQ-006 SHALL have port cmd_half, input, 16; clocks per half-period.
REQ-007 SHALL have port cmd_amp, input, 8; high-level DAC code.
REQ-008 SHALL have port cmd_burst, input, 8; number of full periods, with 0 = continuous.
REQ-009 SHALL have port dac_out, output, 8; registered DAC code.
REQ-010 SHALL have port busy, output, 1; high when the FSM is not IDLE.
REQ-011 SHALL have port period_done, output, 1; one-clock pulse at each full-period end.
REQ-012 SHALL have port burst_done, output, 1; one-clock pulse when a finite burst completes and the FSM returns to IDLE.

Function
REQ-013 FSM states SHALL be IDLE, HIGH and LOW; dac_out = active amp in HIGH and 8'd0 in IDLE and LOW, registered and updated on the same edge as the state change.
REQ-014 Effective half-period SHALL be cmd_half, or DEF_HALF when cmd_half==0. Each HIGH/LOW half SHALL last exactly that many clocks: counter 0..half-1, then toggle state with counter cleared.
REQ-015 Active config (half, amp, burst remaining) and a one-entry shadow register SHALL exist; cmd_ready = !shadow_full.
REQ-016 Accept in IDLE SHALL load the command directly into the active config; the next state is HIGH, so dac_out=amp from the first cycle after the accept edge.
REQ-017 Accept while HIGH/LOW SHALL write the shadow (shadow_full=1); the active config SHALL NOT change mid-period.
REQ-018 Period end (last LOW clock) SHALL pulse period_done and decrement burst remaining if nonzero.
REQ-019 At period end with shadow full, the FSM SHALL load the shadow into active, clear shadow_full and go to HIGH with no gap. This applies in both continuous and finite mode, and preempts any remaining burst.
REQ-020 At period end with shadow empty and an accept on the same edge, the command SHALL load directly into active and the FSM SHALL go to HIGH.
REQ-021 At period end with shadow empty and no accept: continuous mode SHALL repeat with the same config; finite mode with remaining reaching 0 SHALL go to IDLE, set dac_out=0 and pulse burst_done.
REQ-022 Amp 8'd0 SHALL run normally, with dac_out held at 0 and pulses still generated.
REQ-023 Counter and burst arithmetic SHALL be unsigned and SHALL NOT wrap.

Reset
REQ-024 On rst, the block SHALL set state=IDLE, counter=0, shadow_full=0, dac_out=0, busy=0, period_done=0, burst_done=0 and cmd_ready=1.
REQ-025 Reset mid-operation SHALL discard the active and shadow configs; any accept on the reset edge SHALL be ignored.

Configuration
REQ-026 With macro DAC_WAVE_CTRL_ABORT_EN defined, the block SHALL have input abort (1 bit): when high on an edge it SHALL force IDLE, set dac_out=0, clear shadow_full and produce no burst_done pulse. Abort SHALL have priority over accept.
REQ-027 Without DAC_WAVE_CTRL_ABORT_EN, the abort port and logic SHALL be absent and behaviour SHALL otherwise be identical.

Verification
REQ-028 Scenario: rst high for 2 clocks, then release -> dac_out=0, busy=0, cmd_ready=1.
REQ-029 Scenario: accept half=4, amp=200, burst=2 -> dac_out is 200 for 4 clocks then 0 for 4 clocks, twice; period_done pulses twice; burst_done pulses with the last one; busy drops.
REQ-030 Scenario: accept half=0, amp=255, burst=1 -> 300 clocks at 255 then 300 clocks at 0.
REQ-031 Scenario: continuous half=3, amp=100; mid-period accept half=5, amp=50 -> cmd_ready=0 until the period end; the next period is 5 clocks at 50 then 5 clocks at 0 with no gap.
REQ-032 Scenario: burst=1 ends with a same-edge accept half=2, amp=10 -> no IDLE cycle and no burst_done; dac_out=10 on the next cycle.
REQ-033 Scenario: with DAC_WAVE_CTRL_ABORT_EN, pulse abort during HIGH with shadow full -> dac_out=0 next cycle, busy=0, cmd_ready=1, no burst_done.
